// File: rtl/sim_io_pkg.sv
// Shared types and constants for the simulation I/O monitor.
package sim_io_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, TOUT} state_e;

    // Byte offsets of the I/O registers from IO_BASE.
    localparam int unsigned IO_CHAR_OFS = 0;
    localparam int unsigned IO_HALT_OFS = 4;

    // Exit code reported when the watchdog stops a runaway program.
    localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

endpackage

// File: rtl/sim_io_fifo.sv
// Synchronous first-word-fall-through FIFO: push/pop strobes, head data, count, full/empty.
// The caller must not push when full (unless popping) nor pop when empty.
module sim_io_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointer and occupancy update; pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i) begin
                count_q <= count_q + CW'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/sim_io_monitor.sv
// Simulation I/O sink: snoops CPU bus writes to the I/O window, buffers output characters,
// streams them to the host, and reports halt/exit code once output has drained.
// Optional watchdog enabled by defining SIM_WATCHDOG_EN.
module sim_io_monitor
    import sim_io_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    IO_BASE    = 32'h0003_0000,
    parameter int unsigned          FIFO_DEPTH = 16,
    parameter int unsigned          TIMEOUT    = 1_000_000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] mem_a_in,
    input  logic              mem_wr_in,
    input  logic [7:0]        mem_dout_in,
    output logic              io_full_out,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              overflow_out,
    output logic              done_out,
    output logic [7:0]        exit_code_out,
    output logic              timeout_out
);

    localparam logic [ADDR_W-1:0] CharAddr = IO_BASE + ADDR_W'(IO_CHAR_OFS);
    localparam logic [ADDR_W-1:0] HaltAddr = IO_BASE + ADDR_W'(IO_HALT_OFS);

    state_e state_q, state_d;

    logic                        wr_q;
    logic                        char_wr;
    logic                        halt_wr;
    logic                        push_req;
    logic                        push;
    logic                        pop;
    logic [7:0]                  head;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        wd_hit;

    logic       overflow_q;
    logic       done_q;
    logic [7:0] exit_code_q;
    logic [7:0] exit_latch_q;

    assign wr_q    = rdy_in & mem_wr_in;
    assign char_wr = wr_q && (mem_a_in == CharAddr);
    assign halt_wr = wr_q && (mem_a_in == HaltAddr);

    // Characters are only captured while the program is running.
    assign push_req = char_wr && (state_q == RUN);
    assign pop      = !fifo_empty && out_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push     = push_req && (!fifo_full || pop);

    sim_io_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (push),
        .wdata_i (mem_dout_in),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SIM_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q;

    // Watchdog next count: advances on every ready cycle while running.
    always_comb begin
        wd_d = wd_q;
        if (state_q == RUN && rdy_in) wd_d = wd_q + 32'd1;
    end

    assign wd_hit = (state_q == RUN) && rdy_in && (wd_d >= TIMEOUT);

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (state_q == RUN && state_d == TOUT) timeout_q <= 1'b1;
        end
    end

    assign timeout_out = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_hit         = 1'b0;
    assign timeout_out    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state logic; a halt write beats a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_wr)     state_d = DRAIN;
                else if (wd_hit) state_d = TOUT;
            end
            DRAIN:   if (count == '0) state_d = DONE;
            DONE:    state_d = DONE;
            TOUT:    state_d = TOUT;
            default: state_d = RUN;
        endcase
    end

    // Registered status: exit code latch, sticky overflow, done/exit code on terminal entry.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            exit_code_q  <= '0;
            exit_latch_q <= '0;
        end else begin
            if (state_q == RUN && halt_wr) exit_latch_q <= mem_dout_in;
            if (push_req && !push)         overflow_q   <= 1'b1;
            if (state_q == DRAIN && state_d == DONE) begin
                done_q      <= 1'b1;
                exit_code_q <= exit_latch_q;
            end
            if (state_q == RUN && state_d == TOUT) begin
                done_q      <= 1'b1;
                exit_code_q <= EXIT_TIMEOUT;
            end
        end
    end

    assign io_full_out   = fifo_full;
    assign out_valid     = !fifo_empty;
    // Gate stale storage so the data bus reads zero while nothing is buffered.
    assign out_data      = fifo_empty ? 8'h00 : head;
    assign overflow_out  = overflow_q;
    assign done_out      = done_q;
    assign exit_code_out = exit_code_q;

endmodule
